fip_32_addsub_arbiter: RTL and testbench
========================================

Name: fip_32_addsub_arbiter

Overview:
- Time-shares one registered Q16.16 add/sub datapath between NUM_REQ requesters, e.g. the ray-setup, intersection and shading units of the raytracer.
- Round-robin arbitration with a valid/ready request per requester.
- Two-stage pipeline: operand capture, then compute plus overflow detection.
- A single tagged response stream with downstream backpressure.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, $clog2(NUM_REQ): width of the response id.
- INT_SHIFT, 16: fractional bits of the Q format. Documentation only; the arithmetic is format-agnostic two's complement.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ  per requester: 0 = add (x+y), 1 = sub (x-y).
- req_x  in  NUM_REQ*32  packed signed Q16.16 operand x; requester i is at [32*i+:32].
- req_y  in  NUM_REQ*32  packed signed Q16.16 operand y.
- resp_valid  out  1  result valid.
- resp_ready  in  1  downstream accepts the result.
- resp_id  out  ID_W  index of the requester that issued the result.
- resp_data  out  32  signed Q16.16 sum or difference.
- resp_overflow  out  1  signed overflow occurred.
- busy  out  1  any pipeline stage occupied.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: resp_valid=0, resp_id=0, resp_data=0, resp_overflow=0, busy=0. Both stage valid bits are cleared and the round-robin pointer is set to 0.
- Reset mid-operation: in-flight operations are discarded with no response. req_ready is 0 during any cycle in which reset=1.
- Arbitration:
  - Combinational priority search over req_valid, starting at index ptr and wrapping NUM_REQ-1 -> 0.
  - The winner g gets req_ready[g]=1 only when stage 1 can load.
  - Stage 1 can load when s1 is empty, or s1 advances this cycle.
  - ptr <= (g+1) mod NUM_REQ only on an accepted handshake; otherwise ptr holds.
  - req_ready never asserts for an index whose req_valid=0.
- Requester obligation: once a requester raises req_valid, it holds valid and operands stable until accepted. The bench asserts this.
- Stage 1 (s1): on accept, register op, x, y and id.
- Stage 2 (s2 = output registers):
  - Compute r = op ? x-y : x+y, 32-bit wrap-around.
  - Add overflow: x[31]==y[31] && r[31]!=x[31].
  - Sub overflow: x[31]!=y[31] && r[31]!=x[31].
- Advance rules:
  - s2 loads from s1 when s2 is empty or resp_ready=1.
  - s1 advances when it loads into s2.
- Hold rule: resp_* hold stable while resp_valid && !resp_ready.
- Latency: accept at edge N -> resp_valid high after edge N+1, i.e. 2 cycles. Throughput is 1 op/cycle with resp_ready held high.
- Full pipeline: with both stages valid and resp_ready=0, every req_ready is 0. No request is lost or duplicated.
- Simultaneous events: pop of s2, s1->s2 transfer and a new accept into s1 all occur in the same cycle.
- Ordering: responses are in acceptance order. resp_id identifies the requester.
- busy = s1_valid | s2_valid.

Optional Feature:
- Macro: FIP_ADDSUB_SATURATE_EN.
- Defined: on overflow, resp_data clamps to 0x7FFFFFFF if the true result is positive (x[31]=0), or 0x80000000 if negative. resp_overflow is still asserted.
- Undefined: resp_data is the wrapped two's-complement result.
- Latency is the same in both builds.

Decomposition:
- Package fip_32_pkg:
  - typedef logic signed [31:0] fip32_t
  - enum fip_op_e {FIP_ADD=1'b0, FIP_SUB=1'b1}
  - localparams FIP_MAX=32'h7FFFFFFF, FIP_MIN=32'h80000000, INT_SHIFT=16
- Sub-module fip_32_rr_arbiter (parameters NUM_REQ):
  - Inputs: req, advance (handshake accepted), clk, reset.
  - Outputs: one-hot grant and grant index.
  - Owns ptr.
- The datapath stays in the top module.

Test Plan:
- 1.0+1.0: req0 add x=0x00010000, y=0x00010000 -> 2 cycles later resp_data=0x00020000, ovf=0, id=0.
- Positive overflow: req1 add 0x7FFFFFFF+0x00010000 -> ovf=1, data=0x8000FFFF. With FIP_ADDSUB_SATURATE_EN -> 0x7FFFFFFF.
- Negative overflow: req2 sub 0x80000000-0x00000001 -> ovf=1, data=0x7FFFFFFF. With SATURATE_EN -> 0x80000000.
- Negative no overflow: req3 add 0xFFFF0000+0xFFFFFFFF -> 0xFFFEFFFF, ovf=0.
- Fairness: all 4 requesters valid continuously, resp_ready=1 -> grants 0,1,2,3,0,... Responses arrive 1/cycle with ids in the same order.
- Backpressure and reset:
  - resp_ready=0 for 5 cycles with all requesters valid -> exactly 2 accepted, req_ready=0 thereafter, resp_* stable. On release, both results drain in order.
  - Assert reset with both stages full -> next cycle resp_valid=0, busy=0, ptr=0, no stale response.

Source files
------------

// File: rtl/fip_32_pkg.sv
// ============================================================================
// Module   : fip_32_pkg
// Brief    : Shared Q16.16 types and constants for the fip_32 add/sub block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fip_32_pkg;

  typedef logic signed [31:0] fip32_t;

  typedef enum logic {
    FIP_ADD = 1'b0,
    FIP_SUB = 1'b1
  } fip_op_e;

  localparam fip32_t FIP_MAX   = 32'sh7FFFFFFF;
  localparam fip32_t FIP_MIN   = 32'sh80000000;
  localparam int     INT_SHIFT = 16;

endpackage

`default_nettype wire

// File: rtl/fip_32_rr_arbiter.sv
// ============================================================================
// Module   : fip_32_rr_arbiter
// Brief    : Round-robin priority search; the pointer moves past the winner
//            only when the grant is actually accepted.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fip_32_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_sum       = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Candidate index wraps NUM_REQ-1 -> 0, also for non power-of-two counts
      w_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!grant_valid && req[w_cand]) begin
        grant_valid = 1'b1;
        grant_idx   = w_cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fip_32_addsub_arbiter.sv
// ============================================================================
// Module   : fip_32_addsub_arbiter
// Brief    : Shares one two-stage Q16.16 add/sub pipeline among NUM_REQ
//            requesters with a tagged, backpressured response stream.
//            Build option: FIP_ADDSUB_SATURATE_EN clamps overflowed results.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fip_32_addsub_arbiter
  import fip_32_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int INT_SHIFT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0] req_x,
  input  logic [NUM_REQ*32-1:0] req_y,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  resp_overflow,
  output logic                  busy
);

  // The arithmetic is format-agnostic; INT_SHIFT only documents the Q point.
  if (INT_SHIFT < 0 || INT_SHIFT > 31) begin : g_bad_int_shift
    logic unused_shift_cfg;
    assign unused_shift_cfg = 1'b0;
  end

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_valid;
  logic               w_s1_can_load;
  logic               w_s2_load;
  logic               w_accept;

  logic               s1_valid_q, s1_valid_d;
  fip_op_e            s1_op_q, s1_op_d;
  logic [31:0]        s1_x_q, s1_x_d;
  logic [31:0]        s1_y_q, s1_y_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;

  logic               s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]    s2_id_q, s2_id_d;
  logic [31:0]        s2_data_q, s2_data_d;
  logic               s2_ovf_q, s2_ovf_d;

  logic [31:0]        w_sum;
  logic               w_ovf;
  logic [31:0]        w_res;

  fip_32_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req_valid),
    .advance     (w_accept),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  // s2 frees when popped; s1 frees when it moves into s2, all in one cycle
  assign w_s2_load     = s1_valid_q && (!s2_valid_q || resp_ready);
  assign w_s1_can_load = !s1_valid_q || w_s2_load;
  assign w_accept      = w_grant_valid && w_s1_can_load && !reset;
  assign req_ready     = w_grant & {NUM_REQ{w_s1_can_load && !reset}};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_id_d    = s1_id_q;
    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = fip_op_e'(req_op[w_grant_idx]);
      s1_x_d     = req_x[32*w_grant_idx +: 32];
      s1_y_d     = req_y[32*w_grant_idx +: 32];
      s1_id_d    = w_grant_idx;
    end else if (w_s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    w_sum = (s1_op_q == FIP_SUB) ? s1_x_q - s1_y_q : s1_x_q + s1_y_q;
    if (s1_op_q == FIP_SUB) begin
      w_ovf = (s1_x_q[31] != s1_y_q[31]) && (w_sum[31] != s1_x_q[31]);
    end else begin
      w_ovf = (s1_x_q[31] == s1_y_q[31]) && (w_sum[31] != s1_x_q[31]);
    end
    w_res = w_sum;
`ifdef FIP_ADDSUB_SATURATE_EN
    // Sign of x is the sign of the true (unwrapped) result on overflow
    if (w_ovf) begin
      w_res = s1_x_q[31] ? FIP_MIN : FIP_MAX;
    end
`endif
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    if (w_s2_load) begin
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
      s2_data_d  = w_res;
      s2_ovf_d   = w_ovf;
    end else if (resp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= FIP_ADD;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign resp_valid    = s2_valid_q;
  assign resp_id       = s2_id_q;
  assign resp_data     = s2_data_q;
  assign resp_overflow = s2_ovf_q;
  assign busy          = s1_valid_q | s2_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fip_32_addsub_arbiter.sv
// ============================================================================
// Module   : tb_fip_32_addsub_arbiter
// Brief    : Self-checking bench: directed cases plus random traffic against
//            a FIFO-level reference model of the shared add/sub pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fip_32_addsub_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_op;
  logic [N*32-1:0] req_x;
  logic [N*32-1:0] req_y;
  logic            resp_valid;
  logic            resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_data;
  logic            resp_overflow;
  logic            busy;

  always #5 clk = ~clk;

  fip_32_addsub_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .INT_SHIFT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_x         (req_x),
    .req_y         (req_y),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_overflow (resp_overflow),
    .busy          (busy)
  );

  // In-flight op: at most two held, visible at the output once a cycle old
  typedef struct {
    int          id;
    logic [31:0] data;
    logic        ovf;
    int          age;
  } ent_t;

  ent_t        q[$];
  int          resp_log[$];
  int          ref_ptr;
  int          n_tests;
  int          n_fail;
  int          accepts;
  logic [31:0] last_data;
  logic        last_ovf;
  int          last_id;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_op(int id, logic op, logic [31:0] x, logic [31:0] y);
    longint t;
    ent_t   e;
    t = op ? longint'($signed(x)) - longint'($signed(y))
           : longint'($signed(x)) + longint'($signed(y));
    e.id   = id;
    e.age  = 0;
    e.ovf  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    e.data = t[31:0];
`ifdef FIP_ADDSUB_SATURATE_EN
    if (t > 64'sd2147483647)       e.data = 32'h7FFFFFFF;
    else if (t < -64'sd2147483648) e.data = 32'h80000000;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] specials [6];
    specials = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h00010000};
    if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
    return $urandom;
  endfunction

  // Called with inputs settled just after a falling edge
  task automatic step();
    int   g;
    bit   vis;
    logic [N-1:0] exp_ready;
    #1;
    g         = -1;
    exp_ready = '0;
    vis       = (q.size() > 0) && (q[0].age >= 1);
    if (!reset && (q.size() < 2 || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ref_ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);
    check("resp_valid", resp_valid, vis);
    check("busy", busy, q.size() > 0);
    if (vis) begin
      check("resp_id", resp_id, q[0].id);
      check("resp_data", resp_data, q[0].data);
      check("resp_overflow", resp_overflow, q[0].ovf);
      if (resp_ready) begin
        last_data = resp_data;
        last_ovf  = resp_overflow;
        last_id   = resp_id;
      end
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      ref_ptr = 0;
    end else begin
      if (vis && resp_ready) begin
        resp_log.push_back(q[0].id);
        void'(q.pop_front());
      end
      foreach (q[j]) q[j].age++;
      if (g >= 0) begin
        q.push_back(ref_op(g, req_op[g], req_x[32*g +: 32], req_y[32*g +: 32]));
        ref_ptr = (g + 1) % N;
        accepts++;
      end
    end
    @(negedge clk);
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic refill(int pct);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && $urandom_range(99) < pct) begin
        req_valid[i]       = 1'b1;
        req_op[i]          = $urandom_range(1);
        req_x[32*i +: 32]  = rnd_operand();
        req_y[32*i +: 32]  = rnd_operand();
      end
    end
  endtask

  task automatic one_op(string tag, int id, logic op, logic [31:0] x, logic [31:0] y,
                        logic [31:0] ed, logic eo);
    int n0, lat;
    req_valid[id]      = 1'b1;
    req_op[id]         = op;
    req_x[32*id +: 32] = x;
    req_y[32*id +: 32] = y;
    resp_ready         = 1'b1;
    n0  = resp_log.size();
    lat = 0;
    while (resp_log.size() == n0 && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, last_data, ed);
    check({tag, "_ovf"}, last_ovf, eo);
    check({tag, "_id"}, last_id, id);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    req_valid  = '0;
    resp_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    accepts    = 0;
    ref_ptr    = 0;
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_x      = '0;
    req_y      = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step();
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_ovf", resp_overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    one_op("one_plus_one", 0, 1'b0, 32'h00010000, 32'h00010000, 32'h00020000, 1'b0);
`ifdef FIP_ADDSUB_SATURATE_EN
    one_op("pos_ovf", 1, 1'b0, 32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b1);
    one_op("neg_ovf", 2, 1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b1);
`else
    one_op("pos_ovf", 1, 1'b0, 32'h7FFFFFFF, 32'h00010000, 32'h8000FFFF, 1'b1);
    one_op("neg_ovf", 2, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
`endif
    one_op("neg_no_ovf", 3, 1'b0, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFEFFFF, 1'b0);

    // Fairness: everyone requesting, no backpressure
    do_reset();
    resp_log.delete();
    resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      refill(100);
      step();
    end
    check("fair_count", resp_log.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < resp_log.size(); k++) begin
      check("fair_order", resp_log[k], k % N);
    end
    drain();

    // Backpressure: exactly two accepted, then both drain in order
    do_reset();
    resp_log.delete();
    accepts    = 0;
    resp_ready = 1'b0;
    refill(100);
    for (int c = 0; c < 5; c++) step();
    check("bp_accepts", accepts, 2);
    check("bp_full_ready", req_ready, '0);
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check("bp_first", resp_log.size() > 0 ? resp_log[0] : -1, 0);
    check("bp_second", resp_log.size() > 1 ? resp_log[1] : -1, 1);
    drain();

    // Reset with both stages full
    resp_ready = 1'b0;
    refill(100);
    for (int c = 0; c < 3; c++) step();
    check("full_busy", busy, 1'b1);
    resp_log.delete();
    do_reset();
    check("rst_full_valid", resp_valid, 1'b0);
    check("rst_full_busy", busy, 1'b0);
    refill(100);
    #1;
    check("rst_ptr_zero", req_ready, 4'b0001);
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("rst_no_stale", resp_log.size() > 0 ? resp_log[0] : -1, 0);
    drain();

    // Random traffic with random backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      refill(35);
      resp_ready = ($urandom_range(3) != 0);
      reset      = ($urandom_range(299) == 0);
      step();
      reset = 1'b0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
